// File: rtl/eth_frame_script_ctrl.sv
// Script control for the frame detector compare pipeline.
// Tracks frame boundaries on the monitored stream, defers enable-mask
// changes to a boundary, and gates software writes into the per-script
// instruction memories so that only disabled, non-pending scripts change.
module eth_frame_script_ctrl #(
  parameter int C_NUM_SCRIPTS    = 4,
  parameter int C_MEM_ADDR_WIDTH = 11,
  parameter int C_IDLE_TIMEOUT   = 1024,
  localparam int SW              = (C_NUM_SCRIPTS > 1) ? $clog2(C_NUM_SCRIPTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  input  logic [C_NUM_SCRIPTS-1:0]    cfg_en_mask,
  input  logic                        cfg_en_valid,
  output logic [C_NUM_SCRIPTS-1:0]    script_en,
  output logic                        en_pending,
  output logic                        frame_active,
  output logic                        frame_abort,
  input  logic                        wr_req,
  input  logic [SW-1:0]               wr_script,
  input  logic [C_MEM_ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]                 wr_data,
  output logic                        wr_ack,
  output logic                        wr_err,
  output logic [C_NUM_SCRIPTS-1:0]    mem_we,
  output logic [C_MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]                 mem_wdata
);

  localparam int CNT_W = $clog2(C_IDLE_TIMEOUT);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_IN_FRAME = 1'b1
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         wd_cnt;
  logic [C_NUM_SCRIPTS-1:0] pend_mask;
  logic [C_NUM_SCRIPTS-1:0] wr_sel;
  logic                     apply_now;
  logic                     wr_eval;
  logic                     wr_refuse;

  // Boundary tracker with idle watchdog; frame_active mirrors the state.
  // NOTE: state registers use non-blocking assignments so every block
  // samples pre-edge values and ordering between blocks cannot matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      frame_active <= 1'b0;
      frame_abort  <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      frame_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          wd_cnt <= '0;
          if (s_axis_tvalid && !s_axis_tlast) begin
            state        <= S_IN_FRAME;
            frame_active <= 1'b1;
          end
        end
        S_IN_FRAME: begin
          if (s_axis_tvalid) begin
            wd_cnt <= '0;
            if (s_axis_tlast) begin
              state        <= S_IDLE;
              frame_active <= 1'b0;
            end
          end else if (wd_cnt == CNT_W'(C_IDLE_TIMEOUT - 1)) begin
            // Stalled frame: declare it aborted and fall back to a boundary.
            state        <= S_IDLE;
            frame_active <= 1'b0;
            frame_abort  <= 1'b1;
            wd_cnt       <= '0;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        default: begin
          state        <= S_IDLE;
          frame_active <= 1'b0;
          wd_cnt       <= '0;
        end
      endcase
    end
  end

  // A fresh strobe at a quiet boundary applies directly, giving one-cycle latency.
  assign apply_now = (en_pending | cfg_en_valid) & (state == S_IDLE) & ~s_axis_tvalid;

  // Pending-mask latch and boundary-synchronised apply (newest strobe wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      script_en  <= '0;
      pend_mask  <= '0;
      en_pending <= 1'b0;
    end else if (apply_now) begin
      script_en  <= cfg_en_valid ? cfg_en_mask : pend_mask;
      en_pending <= 1'b0;
    end else if (cfg_en_valid) begin
      pend_mask  <= cfg_en_mask;
      en_pending <= 1'b1;
    end
  end

  // Decode the target script one-hot; an out-of-range index decodes to zero.
  // NOTE: combinational outputs get a default first so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < C_NUM_SCRIPTS; i++) begin
      wr_sel[i] = (wr_script == SW'(i));
    end
  end

  // One outstanding request: a response last cycle blocks re-evaluation.
  assign wr_eval   = wr_req & ~wr_ack & ~wr_err;
  assign wr_refuse = ~(|wr_sel)
                   | (|(wr_sel & script_en))
                   | (en_pending & (|(wr_sel & pend_mask)));

  // Write sequencer: one-cycle ack/err and memory strobe; address/data hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      mem_we <= '0;
      if (wr_eval) begin
        if (wr_refuse) begin
          wr_err <= 1'b1;
        end else begin
          wr_ack    <= 1'b1;
          mem_we    <= wr_sel;
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_script_ctrl.sv
// Directed bench for eth_frame_script_ctrl: mask deferral, back-to-back
// frames, write gating, watchdog abort and mid-operation reset.
module tb_eth_frame_script_ctrl;

  logic        clk;
  logic        rst;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic [3:0]  cfg_en_mask;
  logic        cfg_en_valid;
  logic [3:0]  script_en;
  logic        en_pending;
  logic        frame_active;
  logic        frame_abort;
  logic        wr_req;
  logic [1:0]  wr_script;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        wr_err;
  logic [3:0]  mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;

  int passed = 0;
  int total  = 0;

  eth_frame_script_ctrl #(
    .C_NUM_SCRIPTS   (4),
    .C_MEM_ADDR_WIDTH(11),
    .C_IDLE_TIMEOUT  (1024)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .cfg_en_mask  (cfg_en_mask),
    .cfg_en_valid (cfg_en_valid),
    .script_en    (script_en),
    .en_pending   (en_pending),
    .frame_active (frame_active),
    .frame_abort  (frame_abort),
    .wr_req       (wr_req),
    .wr_script    (wr_script),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    cfg_en_mask = '0; cfg_en_valid = 1'b0;
    wr_req = 1'b0; wr_script = '0; wr_addr = '0; wr_data = '0;
    tick(); tick();

    // Reset state
    check("rst_script_en", script_en, 4'b0000);
    check("rst_pending", en_pending, 1'b0);
    check("rst_active", frame_active, 1'b0);
    check("rst_abort", frame_abort, 1'b0);
    check("rst_ack_err", {wr_ack, wr_err}, 2'b00);
    check("rst_mem", {mem_we, mem_addr, mem_wdata}, 47'd0);

    // Mask at an idle boundary: one-cycle latency
    rst = 1'b0;
    repeat (8) tick();
    cfg_en_mask = 4'b0101; cfg_en_valid = 1'b1;
    tick();
    cfg_en_valid = 1'b0;
    check("bnd_script_en", script_en, 4'b0101);
    check("bnd_pending", en_pending, 1'b0);

    // 64-beat frame with two strobes mid-frame: last strobe wins, deferred
    for (int b = 0; b < 64; b++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (b == 63);
      cfg_en_valid  = (b == 5) || (b == 20);
      cfg_en_mask   = (b == 5) ? 4'b1111 : 4'b0011;
      tick();
      if (b == 0) check("mid_active", frame_active, 1'b1);
      if (b == 5) check("mid_pend5", {en_pending, script_en}, 5'b1_0101);
      if (b == 20) check("mid_pend20", {en_pending, script_en}, 5'b1_0101);
    end
    cfg_en_valid = 1'b0;
    check("mid_after_last", {frame_active, en_pending, script_en}, 6'b0_1_0101);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    tick();
    check("mid_applied", {en_pending, script_en}, 5'b0_0011);

    // Back-to-back frames (no gap): apply waits for the first quiet cycle
    s_axis_tvalid = 1'b1; cfg_en_mask = 4'b1100; cfg_en_valid = 1'b1;
    for (int b = 0; b < 6; b++) begin
      s_axis_tlast = (b == 2) || (b == 5);
      tick();
      cfg_en_valid = 1'b0;
      check("b2b_hold", {en_pending, script_en}, 5'b1_0011);
    end
    check("b2b_boundary", frame_active, 1'b0);
    // Quiet cycle with a coinciding strobe: the newer mask is the one applied
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    cfg_en_mask = 4'b0110; cfg_en_valid = 1'b1;
    tick();
    cfg_en_valid = 1'b0;
    check("b2b_apply_new", {en_pending, script_en}, 5'b0_0110);

    // Single-beat frame keeps the tracker idle
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
    tick();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    check("single_beat", frame_active, 1'b0);

    // Write gating with script_en = 0001
    cfg_en_mask = 4'b0001; cfg_en_valid = 1'b1;
    tick();
    cfg_en_valid = 1'b0;
    check("wg_mask", script_en, 4'b0001);
    wr_req = 1'b1; wr_script = 2'd0; wr_addr = 11'd5; wr_data = 32'h1111_2222;
    tick();
    wr_req = 1'b0;
    check("wg_en_err", {wr_ack, wr_err, mem_we}, 6'b01_0000);
    tick();
    wr_req = 1'b1; wr_script = 2'd2; wr_addr = 11'd5; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_req = 1'b0;
    check("wg_ack", {wr_ack, wr_err, mem_we}, 6'b10_0100);
    check("wg_addr_data", {mem_addr, mem_wdata}, {11'd5, 32'hDEAD_BEEF});
    tick();
    check("wg_one_cycle", {wr_ack, mem_we}, 5'b0_0000);
    check("wg_hold", {mem_addr, mem_wdata}, {11'd5, 32'hDEAD_BEEF});

    // Enter a frame with mask 1000 pending; script 3 refused, script 1 accepted
    s_axis_tvalid = 1'b1; cfg_en_mask = 4'b1000; cfg_en_valid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0; cfg_en_valid = 1'b0;
    check("wg_pend", {frame_active, en_pending}, 2'b11);
    wr_req = 1'b1; wr_script = 2'd3; wr_addr = 11'd9; wr_data = 32'h0BAD_0BAD;
    tick();
    wr_req = 1'b0;
    check("wg_pend_err", {wr_ack, wr_err, mem_we}, 6'b01_0000);
    tick();
    wr_req = 1'b1; wr_script = 2'd1; wr_addr = 11'd7; wr_data = 32'h0000_1234;
    tick();
    wr_req = 1'b0;
    check("wg_midframe_ack", {wr_ack, mem_we, mem_addr, mem_wdata},
          {1'b1, 4'b0010, 11'd7, 32'h0000_1234});

    // Watchdog: one beat clears the counter, then 1024 quiet cycles
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    repeat (1023) tick();
    check("wd_pre", {frame_abort, frame_active}, 2'b01);
    tick();
    check("wd_abort", {frame_abort, frame_active, script_en}, 6'b10_0001);
    tick();
    check("wd_apply", {frame_abort, en_pending, script_en}, 6'b00_1000);

    // Reset mid-frame with a pending mask and a held write request
    s_axis_tvalid = 1'b1; cfg_en_mask = 4'b0110; cfg_en_valid = 1'b1;
    tick();
    cfg_en_valid = 1'b0;
    check("rm_setup", {frame_active, en_pending}, 2'b11);
    wr_req = 1'b1; wr_script = 2'd1; wr_addr = 11'd3; wr_data = 32'hCAFE_F00D;
    rst = 1'b1;
    tick();
    check("rm_outputs", {script_en, en_pending, frame_active, frame_abort,
                         wr_ack, wr_err, mem_we}, 13'd0);
    rst = 1'b0; s_axis_tvalid = 1'b0;
    tick();
    check("rm_ack", {wr_ack, wr_err, mem_we, mem_addr, mem_wdata},
          {2'b10, 4'b0010, 11'd3, 32'hCAFE_F00D});
    check("rm_pend_dropped", {en_pending, script_en}, 5'b0_0000);
    tick();
    check("rm_ack_pulse", {wr_ack, mem_we}, 5'b0_0000);
    wr_req = 1'b0;
    tick();
    check("rm_no_apply", script_en, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
